time_seq_ctrl: RTL and testbench

TIME_SEQ_CTRL -- requirements
Module: time_seq_ctrl

---
 rtl/time_seq_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_time_seq_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/time_seq_ctrl.sv
// time_seq_ctrl
//   Timekeeping and sequencing controller for an analogue "ampere meter" clock.
//   It keeps a binary hh:mm:ss count from a 1 Hz prescaler. When run_req rises,
//   the controller can play a startup sweep on the meters (every field ramps up
//   to full scale and back to zero), and then shows the live time.
//
// Configuration macro: AMPERE_SWEEP_EN
//   Defined   - the SWEEP_UP / SWEEP_DOWN startup sequence is built in.
//   Undefined - IDLE goes straight to RUN, sweep_active is tied low, and
//               SWEEP_STEP_CYC is ignored.
//
// Parameters
//   SYSCLKHZ        clk frequency in Hz (prescaler wraps at SYSCLKHZ-1)
//   SWEEP_STEP_CYC  clk cycles per sweep step (>= 2)
//
// Ports
//   clk          system clock
//   Rst          synchronous active-high reset
//   run_req      level request: 1 = run the meter sequence, 0 = go idle
//   set_valid    time-load request
//   set_time     {hour, min, sec} to load, binary
//   set_ready    a load is accepted when set_valid & set_ready (IDLE/RUN only)
//   set_err      one-cycle pulse after a load with an out-of-range field
//   time_data    {hour, min, sec} to the meter PWM stage (registered)
//   En           meter PWM enable
//   sec_tick     one-cycle pulse per elapsed second
//   sweep_active high while the startup sweep runs
module time_seq_ctrl #(
    parameter int SYSCLKHZ       = 50_000_000,
    parameter int SWEEP_STEP_CYC = 500_000
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        run_req,
    input  logic        set_valid,
    input  logic [23:0] set_time,
    output logic        set_ready,
    output logic        set_err,
    output logic [23:0] time_data,
    output logic        En,
    output logic        sec_tick,
    output logic        sweep_active
);

    localparam int            PW       = (SYSCLKHZ > 1) ? $clog2(SYSCLKHZ) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(SYSCLKHZ - 1);

    if (SWEEP_STEP_CYC < 2) begin : g_bad_step
        $error("SWEEP_STEP_CYC must be >= 2");
    end

    typedef enum logic [1:0] {IDLE, SWEEP_UP, SWEEP_DOWN, RUN} state_t;

    state_t        state, state_nxt;
    logic [7:0]    sec, min, hour;
    logic [PW-1:0] presc;
    logic          load, in_range, run_ok, presc_tc;

    assign load     = set_valid & set_ready;
    assign in_range = (set_time[7:0] < 8'd60) && (set_time[15:8] < 8'd60) &&
                      (set_time[23:16] < 8'd24);
    // Timekeeping stops (and the prescaler is held at 0) as soon as the
    // controller is leaving for IDLE, not only once it is there.
    assign run_ok   = run_req && (state != IDLE);
    assign presc_tc = (presc == PRESC_TC);

`ifdef AMPERE_SWEEP_EN
    localparam int SW = $clog2(SWEEP_STEP_CYC);

    logic [SW-1:0] step;
    logic [23:0]   sweep, sweep_up, sweep_dn;
    logic          step_done;

    assign step_done = (step == SW'(SWEEP_STEP_CYC - 1));

    // Each field saturates on its own: hour tops out at 23 while min/sec
    // keep climbing to 59.
    always_comb begin
        sweep_up[23:16] = (sweep[23:16] == 8'd23) ? 8'd23 : sweep[23:16] + 8'd1;
        sweep_up[15:8]  = (sweep[15:8]  == 8'd59) ? 8'd59 : sweep[15:8]  + 8'd1;
        sweep_up[7:0]   = (sweep[7:0]   == 8'd59) ? 8'd59 : sweep[7:0]   + 8'd1;
        sweep_dn[23:16] = (sweep[23:16] == 8'd0)  ? 8'd0  : sweep[23:16] - 8'd1;
        sweep_dn[15:8]  = (sweep[15:8]  == 8'd0)  ? 8'd0  : sweep[15:8]  - 8'd1;
        sweep_dn[7:0]   = (sweep[7:0]   == 8'd0)  ? 8'd0  : sweep[7:0]   - 8'd1;
    end
`else
    assign sweep_active = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (run_req) begin
`ifdef AMPERE_SWEEP_EN
                    state_nxt = SWEEP_UP;
`else
                    state_nxt = RUN;
`endif
                end
            end
`ifdef AMPERE_SWEEP_EN
            SWEEP_UP: begin
                if (step_done && (sweep_up == 24'h17_3B_3B))
                    state_nxt = SWEEP_DOWN;
            end
            // Leave one cycle after the sweep lands on zero so {0,0,0}
            // actually reaches time_data before the live time takes over.
            SWEEP_DOWN: begin
                if (sweep == 24'h0)
                    state_nxt = RUN;
            end
`endif
            RUN:     state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
        if (!run_req)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state     <= IDLE;
            sec       <= '0;
            min       <= '0;
            hour      <= '0;
            presc     <= '0;
            time_data <= '0;
            En        <= 1'b0;
            sec_tick  <= 1'b0;
            set_err   <= 1'b0;
            set_ready <= 1'b1;
`ifdef AMPERE_SWEEP_EN
            sweep        <= '0;
            step         <= '0;
            sweep_active <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            En        <= (state_nxt != IDLE);
            set_ready <= (state_nxt == IDLE) || (state_nxt == RUN);
            set_err   <= load && !in_range;
            sec_tick  <= 1'b0;

            // A good load wins over a simultaneous terminal count; that
            // second is dropped along with its sec_tick.
            if (load && in_range) begin
                hour  <= set_time[23:16];
                min   <= set_time[15:8];
                sec   <= set_time[7:0];
                presc <= '0;
            end else if (!run_ok) begin
                presc <= '0;
            end else if (presc_tc) begin
                presc    <= '0;
                sec_tick <= 1'b1;
                if (sec == 8'd59) begin
                    sec <= 8'd0;
                    if (min == 8'd59) begin
                        min  <= 8'd0;
                        hour <= (hour == 8'd23) ? 8'd0 : hour + 8'd1;
                    end else begin
                        min <= min + 8'd1;
                    end
                end else begin
                    sec <= sec + 8'd1;
                end
            end else begin
                presc <= presc + 1'b1;
            end

            if (!run_req) begin
                time_data <= '0;
            end else begin
                case (state)
                    RUN:                  time_data <= {hour, min, sec};
`ifdef AMPERE_SWEEP_EN
                    SWEEP_UP, SWEEP_DOWN: time_data <= sweep;
`endif
                    default:              time_data <= '0;
                endcase
            end

`ifdef AMPERE_SWEEP_EN
            sweep_active <= (state_nxt == SWEEP_UP) || (state_nxt == SWEEP_DOWN);
            case (state)
                IDLE: begin
                    sweep <= '0;
                    step  <= '0;
                end
                SWEEP_UP, SWEEP_DOWN: begin
                    step <= step_done ? '0 : step + 1'b1;
                    if (step_done)
                        sweep <= (state == SWEEP_UP) ? sweep_up : sweep_dn;
                end
                default: ;
            endcase
`endif
        end
    end

endmodule

// File: tb/tb_time_seq_ctrl.sv
module tb_time_seq_ctrl;

    logic        clk = 1'b0;
    logic        Rst, run_req, set_valid;
    logic [23:0] set_time;
    logic        set_ready, set_err, En, sec_tick, sweep_active;
    logic [23:0] time_data;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       tag;
        logic [23:0] val;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    time_seq_ctrl #(.SYSCLKHZ(10), .SWEEP_STEP_CYC(4)) dut (
        .clk(clk), .Rst(Rst), .run_req(run_req), .set_valid(set_valid),
        .set_time(set_time), .set_ready(set_ready), .set_err(set_err),
        .time_data(time_data), .En(En), .sec_tick(sec_tick),
        .sweep_active(sweep_active)
    );

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [23:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop(input logic [23:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_depth", 24'(sb.size()), 24'd1);
        end else begin
            e = sb.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_rst(input string pfx);
        push({pfx, "_td"}, 24'h0);      push({pfx, "_en"}, 24'd0);
        push({pfx, "_tick"}, 24'd0);    push({pfx, "_err"}, 24'd0);
        push({pfx, "_sweep"}, 24'd0);   push({pfx, "_ready"}, 24'd1);
        pop(time_data);        pop(24'(En));
        pop(24'(sec_tick));    pop(24'(set_err));
        pop(24'(sweep_active)); pop(24'(set_ready));
    endtask

    initial begin
        int ticks;
        Rst = 1'b1; run_req = 1'b0; set_valid = 1'b0; set_time = '0;
        tick(2);
        check_rst("rst");
        Rst = 1'b0;

`ifdef AMPERE_SWEEP_EN
        // Full sweep: step k lands at edge 4k, shows on time_data one edge later.
        run_req = 1'b1;
        push("sw_start_active", 24'd1); push("sw_start_ready", 24'd0);
        tick(1);
        pop(24'(sweep_active)); pop(24'(set_ready));
        for (int n = 1; n <= 473; n++) begin
            if (n == 10) begin
                set_valid = 1'b1; set_time = 24'h01_01_01;
                push("sw_ready_low", 24'd0); pop(24'(set_ready));
            end
            tick(1);
            if (n == 10) begin
                set_valid = 1'b0;
                push("sw_no_err", 24'd0); pop(24'(set_err));
            end
            if (n == 5)   begin push("sw_step1", 24'h01_01_01); pop(time_data); end
            if (n == 93)  begin push("sw_hour23", 24'h17_17_17); pop(time_data); end
            if (n == 121) begin push("sw_step30", 24'h17_1E_1E); pop(time_data); end
            if (n == 237) begin push("sw_top", 24'h17_3B_3B); pop(time_data); end
            if (n == 241) begin push("sw_down1", 24'h16_3A_3A); pop(time_data); end
            if (n == 472) begin push("sw_still_active", 24'd1); pop(24'(sweep_active)); end
            if (n == 473) begin
                push("sw_end_td", 24'h0);     push("sw_end_active", 24'd0);
                push("sw_end_ready", 24'd1);  push("sw_end_en", 24'd1);
                pop(time_data); pop(24'(sweep_active)); pop(24'(set_ready)); pop(24'(En));
            end
        end

        // Reset mid-sweep with run_req still high, then the sweep restarts from 0.
        run_req = 1'b0; tick(1);
        run_req = 1'b1; tick(41);
        Rst = 1'b1; tick(1);
        check_rst("rst_sweep");
        Rst = 1'b0;
        tick(2);
        push("sw_restart0", 24'h0); pop(time_data);
        tick(4);
        push("sw_restart1", 24'h01_01_01); pop(time_data);
        tick(467);
        push("sw_rerun_active", 24'd0); push("sw_rerun_en", 24'd1);
        pop(24'(sweep_active)); pop(24'(En));
`else
        run_req = 1'b1;
        push("run_en", 24'd1); push("run_sweep", 24'd0); push("run_ready", 24'd1);
        tick(1);
        pop(24'(En)); pop(24'(sweep_active)); pop(24'(set_ready));
`endif

        // Rollover 23:59:59 -> 00:00:00 with SYSCLKHZ=10.
        set_valid = 1'b1; set_time = 24'h17_3B_3B;
        tick(1);
        set_valid = 1'b0;
        ticks = 0;
        for (int i = 1; i <= 11; i++) begin
            tick(1);
            ticks += int'(sec_tick);
            if (i == 1)  begin push("roll_loaded", 24'h17_3B_3B); pop(time_data); end
            if (i == 10) begin push("roll_tick", 24'd1); pop(24'(sec_tick)); end
        end
        push("roll_td", 24'h0); push("roll_ticks", 24'd1);
        pop(time_data); pop(24'(ticks));

        // Out-of-range load: error pulse, time unchanged.
        set_valid = 1'b1; set_time = 24'h0C_3C_00;
        tick(1);
        set_valid = 1'b0;
        push("bad_err", 24'd1); push("bad_td", 24'h0);
        pop(24'(set_err)); pop(time_data);
        tick(1);
        push("bad_err_clr", 24'd0); push("bad_td2", 24'h0);
        pop(24'(set_err)); pop(time_data);

        // Load on a terminal-count cycle discards that tick.
        set_valid = 1'b1; set_time = 24'h01_02_03;
        tick(1);
        set_valid = 1'b0;
        tick(9);
        set_valid = 1'b1; set_time = 24'h05_06_07;
        tick(1);
        set_valid = 1'b0;
        push("tc_no_tick", 24'd0); pop(24'(sec_tick));
        tick(1);
        push("tc_loaded", 24'h05_06_07); pop(time_data);
        tick(9);
        push("tc_next_tick", 24'd1); pop(24'(sec_tick));

        // Drop run_req: IDLE, time_data zero, counters hold.
        run_req = 1'b0;
        tick(1);
        push("idle_td", 24'h0); push("idle_en", 24'd0); push("idle_ready", 24'd1);
        pop(time_data); pop(24'(En)); pop(24'(set_ready));
        ticks = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            ticks += int'(sec_tick);
        end
        push("idle_ticks", 24'd0); pop(24'(ticks));
        run_req = 1'b1;
`ifndef AMPERE_SWEEP_EN
        tick(2);
        push("idle_held", 24'h05_06_08); pop(time_data);
`endif

        // Reset has priority over a simultaneous valid load.
        Rst = 1'b1; set_valid = 1'b1; set_time = 24'h09_09_09;
        tick(1);
        check_rst("rst_load");
        Rst = 1'b0; set_valid = 1'b0;
        tick(2);
        push("rst_load_td", 24'h0); pop(time_data);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
